// File: rtl/forward_ctrl_pkg.sv
// Shared constants for the EXE operand-forwarding controller: select encodings,
// the hard-wired zero register and the stall FSM state type.
package forward_ctrl_pkg;

  localparam logic [1:0] SEL_OPERAND = 2'd0;
  localparam logic [1:0] SEL_EXMEM   = 2'd1;
  localparam logic [1:0] SEL_MEMWB   = 2'd2;

  localparam logic [4:0] REG_ZERO    = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/forward_ctrl_match.sv
// Combinational forwarding match for one source operand against the EX and MEM
// shadow slots; also flags a hit on a load sitting in EX (load-use hazard).
module fwd_match
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SEL_W = 2
) (
  input  logic                 use_i,
  input  logic [REG_AW-1:0]    src_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_reg_write_i,
  input  logic                 ex_mem_read_i,
  input  logic [REG_AW-1:0]    ex_write_reg_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_reg_write_i,
  input  logic [REG_AW-1:0]    mem_write_reg_i,
  output logic [NUM_SEL_W-1:0] sel_o,
  output logic                 load_hit_o
);

  logic src_nz_s;
  logic ex_hit_s;
  logic mem_hit_s;

  // $0 is never forwarded; the nearer (EX) producer wins over MEM
  always_comb begin
    src_nz_s   = (src_i != REG_AW'(REG_ZERO));
    ex_hit_s   = use_i & src_nz_s & ex_valid_i & ex_reg_write_i & (ex_write_reg_i == src_i);
    mem_hit_s  = use_i & src_nz_s & mem_valid_i & mem_reg_write_i & (mem_write_reg_i == src_i);
    load_hit_o = ex_hit_s & ex_mem_read_i;
    if (ex_hit_s && !ex_mem_read_i) begin
      sel_o = NUM_SEL_W'(SEL_EXMEM);
    end else if (mem_hit_s) begin
      sel_o = NUM_SEL_W'(SEL_MEMWB);
    end else begin
      sel_o = NUM_SEL_W'(SEL_OPERAND);
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// ID->EXE forwarding controller: shadow EX/MEM slots, registered select codes,
// one-cycle load-use stall. Optional statistics counters under `FWD_STATS_EN.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SEL_W = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ID_Valid_IN,
  input  logic [REG_AW-1:0]    ID_RegA_IN,
  input  logic [REG_AW-1:0]    ID_RegB_IN,
  input  logic                 ID_UsesA_IN,
  input  logic                 ID_UsesB_IN,
  input  logic                 ID_StoreData_IN,
  input  logic [REG_AW-1:0]    ID_WriteReg_IN,
  input  logic                 ID_RegWrite_IN,
  input  logic                 ID_MemRead_IN,
  input  logic                 Pipe_Stall_IN,
  input  logic                 Flush_IN,
  output logic [NUM_SEL_W-1:0] RegA_Select_OUT,
  output logic [NUM_SEL_W-1:0] RegB_Select_OUT,
  output logic [NUM_SEL_W-1:0] MEM_Data_select_OUT,
  output logic                 Stall_ID_OUT,
  output logic                 Bubble_OUT
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]     Stall_Count_OUT,
  output logic [CNT_W-1:0]     Fwd_Count_OUT
`endif
);

  fwd_state_e          state_q;
  logic                ex_valid_q, ex_reg_write_q, ex_mem_read_q;
  logic [REG_AW-1:0]   ex_write_reg_q;
  logic                mem_valid_q, mem_reg_write_q;
  logic [REG_AW-1:0]   mem_write_reg_q;

  logic [NUM_SEL_W-1:0] sel_a_s, sel_b_s, sel_m_s;
  logic                 lhit_a_s, lhit_b_s, lhit_m_s;
  logic                 hazard_s, advance_s, enter_s;

  fwd_match #(.REG_AW(REG_AW), .NUM_SEL_W(NUM_SEL_W)) u_match_a (
    .use_i(ID_Valid_IN & ID_UsesA_IN), .src_i(ID_RegA_IN),
    .ex_valid_i(ex_valid_q), .ex_reg_write_i(ex_reg_write_q),
    .ex_mem_read_i(ex_mem_read_q), .ex_write_reg_i(ex_write_reg_q),
    .mem_valid_i(mem_valid_q), .mem_reg_write_i(mem_reg_write_q),
    .mem_write_reg_i(mem_write_reg_q), .sel_o(sel_a_s), .load_hit_o(lhit_a_s)
  );

  fwd_match #(.REG_AW(REG_AW), .NUM_SEL_W(NUM_SEL_W)) u_match_b (
    .use_i(ID_Valid_IN & ID_UsesB_IN), .src_i(ID_RegB_IN),
    .ex_valid_i(ex_valid_q), .ex_reg_write_i(ex_reg_write_q),
    .ex_mem_read_i(ex_mem_read_q), .ex_write_reg_i(ex_write_reg_q),
    .mem_valid_i(mem_valid_q), .mem_reg_write_i(mem_reg_write_q),
    .mem_write_reg_i(mem_write_reg_q), .sel_o(sel_b_s), .load_hit_o(lhit_b_s)
  );

  fwd_match #(.REG_AW(REG_AW), .NUM_SEL_W(NUM_SEL_W)) u_match_m (
    .use_i(ID_Valid_IN & ID_StoreData_IN), .src_i(ID_RegB_IN),
    .ex_valid_i(ex_valid_q), .ex_reg_write_i(ex_reg_write_q),
    .ex_mem_read_i(ex_mem_read_q), .ex_write_reg_i(ex_write_reg_q),
    .mem_valid_i(mem_valid_q), .mem_reg_write_i(mem_reg_write_q),
    .mem_write_reg_i(mem_write_reg_q), .sel_o(sel_m_s), .load_hit_o(lhit_m_s)
  );

  // In STALL the load has moved to MEM, so no second stall is raised for it
  always_comb begin
    hazard_s     = ID_Valid_IN & (state_q == RUN) & (lhit_a_s | lhit_b_s | lhit_m_s);
    Stall_ID_OUT = hazard_s & ~Flush_IN;
    advance_s    = ~Pipe_Stall_IN;
    enter_s      = advance_s & ~Flush_IN & ~hazard_s;
  end

  // Shadow slots, stall FSM and registered select outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q             <= RUN;
      ex_valid_q          <= 1'b0;
      ex_reg_write_q      <= 1'b0;
      ex_mem_read_q       <= 1'b0;
      ex_write_reg_q      <= '0;
      mem_valid_q         <= 1'b0;
      mem_reg_write_q     <= 1'b0;
      mem_write_reg_q     <= '0;
      RegA_Select_OUT     <= '0;
      RegB_Select_OUT     <= '0;
      MEM_Data_select_OUT <= '0;
      Bubble_OUT          <= 1'b0;
    end else if (advance_s) begin
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_write_reg_q <= ex_write_reg_q;
      if (enter_s) begin
        state_q             <= RUN;
        ex_valid_q          <= ID_Valid_IN;
        ex_reg_write_q      <= ID_Valid_IN & ID_RegWrite_IN;
        ex_mem_read_q       <= ID_Valid_IN & ID_MemRead_IN;
        ex_write_reg_q      <= ID_WriteReg_IN;
        RegA_Select_OUT     <= sel_a_s;
        RegB_Select_OUT     <= sel_b_s;
        MEM_Data_select_OUT <= sel_m_s;
        Bubble_OUT          <= ~ID_Valid_IN;
      end else begin
        // flush or load-use: a bubble enters EXE; flush always lands in RUN
        state_q             <= Flush_IN ? RUN : STALL;
        ex_valid_q          <= 1'b0;
        ex_reg_write_q      <= 1'b0;
        ex_mem_read_q       <= 1'b0;
        ex_write_reg_q      <= '0;
        RegA_Select_OUT     <= '0;
        RegB_Select_OUT     <= '0;
        MEM_Data_select_OUT <= '0;
        Bubble_OUT          <= 1'b1;
      end
    end else begin
      state_q <= state_q;
    end
  end

`ifdef FWD_STATS_EN
  logic stall_evt_s, fwd_evt_s;

  always_comb begin
    stall_evt_s = advance_s & ~Flush_IN & hazard_s;
    fwd_evt_s   = enter_s & ((sel_a_s | sel_b_s | sel_m_s) != '0);
  end

  // Saturating event counters, frozen together with the pipeline
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Stall_Count_OUT <= '0;
      Fwd_Count_OUT   <= '0;
    end else begin
      if (stall_evt_s && (Stall_Count_OUT != '1)) begin
        Stall_Count_OUT <= Stall_Count_OUT + CNT_W'(1);
      end else begin
        Stall_Count_OUT <= Stall_Count_OUT;
      end
      if (fwd_evt_s && (Fwd_Count_OUT != '1)) begin
        Fwd_Count_OUT <= Fwd_Count_OUT + CNT_W'(1);
      end else begin
        Fwd_Count_OUT <= Fwd_Count_OUT;
      end
    end
  end
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: each issued ID instruction pushes its
// hand-derived EXE select/bubble codes, popped and compared one edge later.
module tb_forward_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ID_Valid_IN, ID_UsesA_IN, ID_UsesB_IN, ID_StoreData_IN;
  logic [4:0] ID_RegA_IN, ID_RegB_IN, ID_WriteReg_IN;
  logic       ID_RegWrite_IN, ID_MemRead_IN, Pipe_Stall_IN, Flush_IN;
  logic [1:0] RegA_Select_OUT, RegB_Select_OUT, MEM_Data_select_OUT;
  logic       Stall_ID_OUT, Bubble_OUT;
`ifdef FWD_STATS_EN
  logic [31:0] Stall_Count_OUT, Fwd_Count_OUT;
`endif

  typedef struct packed {
    logic v; logic [4:0] ra; logic [4:0] rb; logic ua; logic ub; logic st;
    logic [4:0] wr; logic rw; logic mr;
  } instr_t;

  typedef struct packed {
    logic [1:0] a; logic [1:0] b; logic [1:0] m; logic bub;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_stalls = 0;
  int   exp_fwds = 0;

  always #5 CLK = ~CLK;

  forward_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .ID_Valid_IN(ID_Valid_IN), .ID_RegA_IN(ID_RegA_IN), .ID_RegB_IN(ID_RegB_IN),
    .ID_UsesA_IN(ID_UsesA_IN), .ID_UsesB_IN(ID_UsesB_IN),
    .ID_StoreData_IN(ID_StoreData_IN), .ID_WriteReg_IN(ID_WriteReg_IN),
    .ID_RegWrite_IN(ID_RegWrite_IN), .ID_MemRead_IN(ID_MemRead_IN),
    .Pipe_Stall_IN(Pipe_Stall_IN), .Flush_IN(Flush_IN),
    .RegA_Select_OUT(RegA_Select_OUT), .RegB_Select_OUT(RegB_Select_OUT),
    .MEM_Data_select_OUT(MEM_Data_select_OUT),
    .Stall_ID_OUT(Stall_ID_OUT), .Bubble_OUT(Bubble_OUT)
`ifdef FWD_STATS_EN
    , .Stall_Count_OUT(Stall_Count_OUT), .Fwd_Count_OUT(Fwd_Count_OUT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{1'b1, rs, rt, 1'b1, 1'b1, 1'b0, rd, 1'b1, 1'b0};
  endfunction

  function automatic instr_t lw(input logic [4:0] rt, input logic [4:0] rs);
    return '{1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b0, rt, 1'b1, 1'b1};
  endfunction

  function automatic instr_t sw(input logic [4:0] rt, input logic [4:0] rs);
    return '{1'b1, rs, rt, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
  endfunction

  function automatic instr_t nop();
    return '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
  endfunction

  function automatic exp_t ex(input logic [1:0] a, input logic [1:0] b, input logic [1:0] m, input logic bub);
    return '{a, b, m, bub};
  endfunction

  task automatic drive(input instr_t ins, input logic ps, input logic fl);
    ID_Valid_IN = ins.v;   ID_RegA_IN = ins.ra;  ID_RegB_IN = ins.rb;
    ID_UsesA_IN = ins.ua;  ID_UsesB_IN = ins.ub; ID_StoreData_IN = ins.st;
    ID_WriteReg_IN = ins.wr; ID_RegWrite_IN = ins.rw; ID_MemRead_IN = ins.mr;
    Pipe_Stall_IN = ps;    Flush_IN = fl;
  endtask

  task automatic step(input string tag, input instr_t ins, input logic ps, input logic fl,
                      input logic exp_stall, input exp_t e);
    exp_t got;
    @(negedge CLK);
    drive(ins, ps, fl);
    #1;
    check({tag, ".stall"}, {31'd0, Stall_ID_OUT}, {31'd0, exp_stall});
    sb_q.push_back(e);
    if (!ps && !fl && exp_stall) exp_stalls++;
    if (!ps && !fl && !exp_stall && ((e.a | e.b | e.m) != 2'd0)) exp_fwds++;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, ".a"},   {30'd0, RegA_Select_OUT},     {30'd0, got.a});
      check({tag, ".b"},   {30'd0, RegB_Select_OUT},     {30'd0, got.b});
      check({tag, ".m"},   {30'd0, MEM_Data_select_OUT}, {30'd0, got.m});
      check({tag, ".bub"}, {31'd0, Bubble_OUT},          {31'd0, got.bub});
    end
  endtask

  task automatic drain();
    step("nop0", nop(), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("nop1", nop(), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".a"},     {30'd0, RegA_Select_OUT},     32'd0);
    check({tag, ".b"},     {30'd0, RegB_Select_OUT},     32'd0);
    check({tag, ".m"},     {30'd0, MEM_Data_select_OUT}, 32'd0);
    check({tag, ".bub"},   {31'd0, Bubble_OUT},          32'd0);
    check({tag, ".stall"}, {31'd0, Stall_ID_OUT},        32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef FWD_STATS_EN
    check({tag, ".stall_cnt"}, Stall_Count_OUT, 32'(exp_stalls));
    check({tag, ".fwd_cnt"},   Fwd_Count_OUT,   32'(exp_fwds));
`else
    check({tag, ".sb_drained"}, 32'(sb_q.size()), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    #12;
    check_zero_outputs("reset");
    check_stats("reset");
    @(negedge CLK);
    RESET = 1'b1;
    drain();

    // back-to-back ALU dependency forwards from EX/MEM
    step("t1_add", alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t1_sub", alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b0, 1'b0, ex(2'd1, 2'd0, 2'd0, 1'b0));
    drain();

    // one instruction gap forwards from MEM/WB on both operands
    step("t2_add", alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t2_nop", nop(),                 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t2_or",  alu(5'd6, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0, ex(2'd2, 2'd2, 2'd0, 1'b0));
    drain();

    // load-use: exactly one bubble, then MEM/WB forward
    step("t3_lw",   lw(5'd2, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t3_add0", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b1, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t3_add1", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd2, 2'd0, 2'd0, 1'b0));
    check_stats("t3");
    drain();

    // $0 never forwarded; nearest of two producers wins
    step("t4_w0",  alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t4_r0",  alu(5'd5, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t4_p8a", alu(5'd8, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t4_p8b", alu(5'd8, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t4_u8",  alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 1'b0, ex(2'd1, 2'd1, 2'd0, 1'b0));
    drain();

    // store data forwarding goes to MEM_Data_select, not operand B
    step("t5_add", alu(5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t5_sw",  sw(5'd9, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd1, 1'b0));
    drain();

    // global freeze mid-hazard: outputs hold, stall request still visible
    step("t6_lw",  lw(5'd2, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step($sformatf("t6_frz%0d", i), alu(5'd7, 5'd2, 5'd1), 1'b1, 1'b0, 1'b1,
           ex(2'd0, 2'd0, 2'd0, 1'b0));
    end
    step("t6_bub", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b1, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t6_use", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd2, 2'd0, 2'd0, 1'b0));
    drain();

    // flush while in STALL: bubble, then hazard detection works again
    step("t7_lw",   lw(5'd2, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t7_haz",  alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b1, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t7_fl",   alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b1, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t7_or",   alu(5'd6, 5'd2, 5'd2), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t7_lw2",  lw(5'd2, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t7_haz2", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b1, ex(2'd0, 2'd0, 2'd0, 1'b1));
    step("t7_use",  alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd2, 2'd0, 2'd0, 1'b0));
    check_stats("t7");
    drain();

    // reset while in STALL clears outputs and slots
    step("t8_lw",  lw(5'd2, 5'd1),        1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    step("t8_haz", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b1, ex(2'd0, 2'd0, 2'd0, 1'b1));
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    exp_stalls = 0;
    exp_fwds = 0;
    check_zero_outputs("t8_rst");
    check_stats("t8_rst");
    @(negedge CLK);
    RESET = 1'b1;
    step("t8_post", alu(5'd7, 5'd2, 5'd1), 1'b0, 1'b0, 1'b0, ex(2'd0, 2'd0, 2'd0, 1'b0));
    check_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Producer side of the EXE operand-forwarding interface.
- Sits at the ID→EXE boundary and tracks destination registers of instructions in flight in EXE and MEM.
- Generates the registered RegA_Select / RegB_Select / MEM_Data_select codes that EXE consumes.
- Detects load-use hazards and stalls ID by one cycle, inserting a bubble.

Parameters:
- REG_AW, 5, register-address width.
- NUM_SEL_W, 2, select-code width.
- CNT_W, 32, statistics counter width (used only under FWD_STATS_EN).

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- ID_Valid_IN  in  1  ID holds a real instruction
- ID_RegA_IN  in  REG_AW  rs address
- ID_RegB_IN  in  REG_AW  rt address
- ID_UsesA_IN  in  1  instruction reads rs
- ID_UsesB_IN  in  1  instruction reads rt as ALU operand B
- ID_StoreData_IN  in  1  instruction is a store; rt is the store data
- ID_WriteReg_IN  in  REG_AW  destination
- ID_RegWrite_IN  in  1  writes a register
- ID_MemRead_IN  in  1  load
- Pipe_Stall_IN  in  1  global freeze from MEM/IF
- Flush_IN  in  1  branch/jump squash of the ID instruction
- RegA_Select_OUT  out  NUM_SEL_W  to EXE: 0 operand, 1 EX/MEM ALU result, 2 MEM/WB result
- RegB_Select_OUT  out  NUM_SEL_W  same encoding, for operand B
- MEM_Data_select_OUT  out  NUM_SEL_W  store-data source, same encoding
- Stall_ID_OUT  out  1  hold IF/ID, inject bubble into EXE
- Bubble_OUT  out  1  registered; EXE instruction is a bubble

Behaviour:
- Reset (RESET asynchronous, active-low; clock CLK; RESET low): all select outputs 0, Bubble_OUT 0, Stall_ID_OUT 0. Shadow EX and MEM slots are invalid, with WriteReg 0, RegWrite 0, MemRead 0. FSM is RUN.
- Shadow pipeline: slot EXs holds {WriteReg, RegWrite, MemRead, valid} of the instruction in EXE; slot MEMs holds the same for the instruction in MEM.
- Each CLK edge with Pipe_Stall_IN=0: MEMs←EXs, then EXs←ID info. If the ID instruction is stalled, flushed or invalid, EXs←invalid.
- Pipe_Stall_IN=1 freezes all state and outputs; Stall_ID_OUT is still computed combinationally.
- Hit definition: a hit on slot S for source r requires valid, RegWrite, WriteReg==r, and r≠0. Register $0 is never forwarded.
- Select computed in ID from the current slots, then registered into the *_OUT outputs at the same edge the instruction enters EXE. Latency is therefore exactly 1 cycle, aligned with the EXE operands.
- Select code for the instruction entering EXE (same rule for A, B and store data):
  - EXs hit (and EXs not a load) → 1, because the producer will be in MEM.
  - Else MEMs hit → 2.
  - Else 0.
  - The nearest producer always wins on a simultaneous match.
- The select for a given source is 0 whenever the corresponding Uses/StoreData flag is low.
- Load-use hazard is combinational: ID_Valid_IN & EXs.MemRead & EXs hit on a used source → Stall_ID_OUT=1.
- FSM states:
  - RUN: on a hazard with Pipe_Stall_IN=0, go to STALL. Registered outputs become 0 and Bubble_OUT=1.
  - STALL (one cycle): the load is now in MEMs, so the select resolves to 2. Stall_ID_OUT is forced 0 and the FSM returns to RUN.
  - At most one stall cycle per load.
- Flush_IN=1 at an edge: the ID instruction enters EXE as a bubble with all selects 0. The FSM returns to RUN even if it was in STALL. Flush has priority over stall.
- Reset mid-stall: FSM returns to RUN immediately and all slots are invalidated.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds outputs Stall_Count_OUT and Fwd_Count_OUT (CNT_W each), reset to 0.
  - Stall_Count_OUT increments on each RUN→STALL transition.
  - Fwd_Count_OUT increments once per instruction entering EXE with any nonzero select.
  - Both counters saturate at all-ones and are frozen under Pipe_Stall_IN.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: select encodings SEL_OPERAND=0, SEL_EXMEM=1, SEL_MEMWB=2; REG_ZERO=0; FSM state constants RUN/STALL.
- One sub-module, fwd_match: combinational (slot, source) → select code. It is instantiated three times (A, B, store data).

Test Plan:
1. add $3,… then sub $4,$3,$5 back-to-back → the sub's RegA_Select_OUT=1, no stall.
2. add $3 then nop then or $6,$3,$3 → RegA=RegB=2 in the cycle the or is in EXE.
3. lw $2 then add $7,$2,$1 → Stall_ID_OUT=1 for one cycle and Bubble_OUT=1. The next cycle the add enters EXE with RegA_Select_OUT=2; exactly one stall.
4. add $0,… then use of $0 → selects stay 0. Also: two producers of $8 in EXs and MEMs → select 1 (nearest wins).
5. sw $9 after add $9 → MEM_Data_select_OUT=1, RegB_Select_OUT=0.
6. Pipe_Stall_IN held 3 cycles mid-hazard → outputs frozen. Flush_IN during STALL → bubble, FSM back to RUN. RESET low mid-stall → all outputs 0. With FWD_STATS_EN, case 3 gives Stall_Count_OUT=1.
